// File: rtl/ni_response_builder.sv
// Network-interface response packetizer: turns a pending target response into
// a header flit plus either read-data body/tail flits or a single write-ack tail.
`ifndef SOURCEWD
`define SOURCEWD 8
`endif

module ni_response_builder #(
  parameter int SOURCEWD = `SOURCEWD,
  parameter int DATAWD   = 32,
  parameter int FLITWD   = 34,
  parameter int MAXBURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                full_response,
  input  logic                packet_type_is_read,
  input  logic [SOURCEWD-1:0] transaction_target,
  input  logic                resp_valid,
  input  logic [DATAWD-1:0]   resp_data,
  input  logic                resp_last,
  output logic                resp_accept,
  output logic [FLITWD-1:0]   flit_out,
  output logic                flit_valid,
  input  logic                flit_stall,
  output logic                processing_response,
  output logic                transaction_complete,
  output logic [SOURCEWD-1:0] message_source,
  output logic                burst_overrun,
  output logic [2:0]          fsm_state
);

  localparam int CNTWD = $clog2(MAXBURST) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    WACK    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [SOURCEWD-1:0] target_q;
  logic                is_read_q;
  logic [CNTWD-1:0]    beat_cnt;
  logic                overrun_q;
  logic                at_limit;
  logic                is_tail;
  logic                beat_take;

  // Handshakes: a read beat moves when resp_valid && resp_accept; a flit moves
  // when flit_valid && !flit_stall. In PAYLOAD both describe the same event.
  assign at_limit  = (beat_cnt == CNTWD'(MAXBURST - 1));
  assign is_tail   = resp_last | at_limit;
  assign beat_take = (state == PAYLOAD) & resp_valid & ~flit_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      target_q  <= '0;
      is_read_q <= 1'b0;
      beat_cnt  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (full_response) begin
          target_q  <= transaction_target;
          is_read_q <= packet_type_is_read;
        end
      end else if (beat_take) begin
        beat_cnt <= beat_cnt + CNTWD'(1);
      end
      // Sticky: the target kept streaming past the packet size limit.
      if (beat_take && at_limit && !resp_last) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next           = state;
    flit_out             = '0;
    flit_valid           = 1'b0;
    resp_accept          = 1'b0;
    transaction_complete = 1'b0;
    message_source       = '0;
    case (state)
      IDLE: begin
        if (full_response) state_next = HEADER;
      end
      HEADER: begin
        flit_valid                   = 1'b1;
        flit_out[FLITWD-1:FLITWD-2]  = 2'b01;
        flit_out[FLITWD-3]           = is_read_q;
        flit_out[SOURCEWD-1:0]       = target_q;
        if (!flit_stall) state_next  = is_read_q ? PAYLOAD : WACK;
      end
      PAYLOAD: begin
        resp_accept                  = ~flit_stall;
        flit_valid                   = resp_valid;
        flit_out[FLITWD-1:FLITWD-2]  = is_tail ? 2'b11 : 2'b10;
        flit_out[DATAWD-1:0]         = resp_data;
        if (beat_take && is_tail) state_next = DONE;
      end
      WACK: begin
        flit_valid                   = 1'b1;
        flit_out[FLITWD-1:FLITWD-2]  = 2'b11;
        if (!flit_stall) state_next  = DONE;
      end
      DONE: begin
        transaction_complete = 1'b1;
        message_source       = target_q;
        state_next           = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign processing_response = (state != IDLE);
  assign burst_overrun       = overrun_q;
  assign fsm_state           = state;

endmodule

// File: tb/tb_ni_response_builder.sv
// Randomized bench for ni_response_builder: a packet-level model predicts the
// flit stream and completion records; one negedge process compares them.
module tb_ni_response_builder;
  localparam int SW = 8;
  localparam int DW = 32;
  localparam int FW = 34;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          full_response = 1'b0;
  logic          packet_type_is_read = 1'b0;
  logic [SW-1:0] transaction_target = '0;
  logic          resp_valid = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic          resp_last = 1'b0;
  logic          resp_accept;
  logic [FW-1:0] flit_out;
  logic          flit_valid;
  logic          flit_stall = 1'b0;
  logic          processing_response;
  logic          transaction_complete;
  logic [SW-1:0] message_source;
  logic          burst_overrun;
  logic [2:0]    fsm_state;

  always #5 clk = ~clk;

  ni_response_builder #(.SOURCEWD(SW), .DATAWD(DW), .FLITWD(FW), .MAXBURST(MB)) dut (
    .clk(clk), .rst(rst), .full_response(full_response),
    .packet_type_is_read(packet_type_is_read), .transaction_target(transaction_target),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .resp_accept(resp_accept), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_stall(flit_stall), .processing_response(processing_response),
    .transaction_complete(transaction_complete), .message_source(message_source),
    .burst_overrun(burst_overrun), .fsm_state(fsm_state)
  );

  typedef struct packed {
    logic [SW-1:0] tgt;
    logic          ovr;
  } done_t;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];
  done_t         done_q[$];
  logic          exp_ovr = 1'b0;
  logic [SW-1:0] last_msrc = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Packet format rules.
  function automatic logic [FW-1:0] hdr_flit(input logic rd, input logic [SW-1:0] t);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1:FW-2] = 2'b01;
    f[FW-3] = rd;
    f[SW-1:0] = t;
    return f;
  endfunction

  function automatic logic [FW-1:0] data_flit(input logic tail, input logic [DW-1:0] d);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1:FW-2] = tail ? 2'b11 : 2'b10;
    f[DW-1:0] = d;
    return f;
  endfunction

  // Compare process.
  logic [FW-1:0] hold_flit = '0;
  logic          hold_pend = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (hold_pend) begin
        check("stall_hold_valid", 64'(flit_valid), 64'(1));
        check("stall_hold_flit", 64'(flit_out), 64'(hold_flit));
      end
      hold_pend = flit_valid && flit_stall;
      hold_flit = flit_out;
      if (flit_stall) check("accept_while_stalled", 64'(resp_accept), 64'(0));
      if (!processing_response) begin
        check("idle_flit_valid", 64'(flit_valid), 64'(0));
        check("idle_resp_accept", 64'(resp_accept), 64'(0));
      end
      if (!transaction_complete) check("msrc_zero", 64'(message_source), 64'(0));
      if (flit_valid && !flit_stall) begin
        got_q.push_back(flit_out);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flit actual=%0h required=none at %0t", flit_out, $time);
        end else begin
          check("flit", 64'(flit_out), 64'(exp_q.pop_front()));
        end
      end
      if (transaction_complete) begin
        last_msrc = message_source;
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_complete actual=1 required=0 at %0t", $time);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("message_source", 64'(message_source), 64'(d.tgt));
          check("burst_overrun", 64'(burst_overrun), 64'(d.ovr));
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flit_valid"}, 64'(flit_valid), 64'(0));
    check({tag, "_flit_out"}, 64'(flit_out), 64'(0));
    check({tag, "_resp_accept"}, 64'(resp_accept), 64'(0));
    check({tag, "_processing"}, 64'(processing_response), 64'(0));
    check({tag, "_complete"}, 64'(transaction_complete), 64'(0));
    check({tag, "_msrc"}, 64'(message_source), 64'(0));
    check({tag, "_overrun"}, 64'(burst_overrun), 64'(0));
  endtask

  // One packet: predict, then drive cycle by cycle from posedge+1.
  // last_idx < 0 means resp_last never asserted; base == 0 means random data.
  task automatic run_packet(input logic rd, input logic [SW-1:0] tgt, input int nb,
                            input int last_idx, input logic [DW-1:0] base,
                            input int stall_pct, input int valid_pct,
                            input logic [63:0] stall_map, input int abort_after);
    logic [DW-1:0] beats[$];
    int  n_exp;
    int  bidx = 0;
    int  cyc = 0;
    int  consumed_n = 0;
    bit  done = 0;
    bit  cons = 0;
    bit  limited;
    for (int i = 0; i < nb; i++) beats.push_back((base != 0) ? base + DW'(i) : DW'($urandom));
    exp_q.push_back(hdr_flit(rd, tgt));
    if (rd) begin
      limited = !(last_idx >= 0 && last_idx < MB);
      n_exp = limited ? MB : last_idx + 1;
      for (int i = 0; i < n_exp; i++) exp_q.push_back(data_flit(i == n_exp - 1, beats[i]));
      if (limited) exp_ovr = 1'b1;
    end else begin
      exp_q.push_back(data_flit(1'b1, '0));
    end
    if (abort_after < 0) done_q.push_back('{tgt: tgt, ovr: exp_ovr});

    full_response = 1'b1;
    packet_type_is_read = rd;
    transaction_target = tgt;
    @(posedge clk); #1;
    while (!done && cyc < 400) begin
      full_response = 1'($urandom_range(0, 1));
      transaction_target = SW'($urandom);
      flit_stall = (cyc < 64 && stall_map[cyc]) || ($urandom_range(0, 99) < stall_pct);
      if (!(resp_valid && !cons)) begin
        if (bidx < nb && $urandom_range(0, 99) < valid_pct) begin
          resp_valid = 1'b1;
          resp_data = beats[bidx];
          resp_last = (bidx == last_idx);
        end else begin
          resp_valid = 1'b0;
          resp_data = DW'($urandom);
          resp_last = 1'b0;
        end
      end
      @(negedge clk);
      cons = resp_valid && resp_accept;
      if (cons) begin
        bidx++;
        consumed_n++;
      end
      done = transaction_complete;
      if (cons && abort_after >= 0 && consumed_n == abort_after) begin
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_ovr = 1'b0;
        @(posedge clk); #3;
        resp_valid = 1'b0;
        resp_last = 1'b0;
        full_response = 1'b0;
        flit_stall = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    full_response = 1'b0;
    resp_valid = 1'b0;
    resp_last = 1'b0;
    flit_stall = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL packet_timeout actual=no_complete required=complete tgt=%0h", tgt);
    end
    check("idle_after_done", 64'(processing_response), 64'(0));
    check("exp_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    #5 rst = 1'b1;
    @(posedge clk); #1;

    // Write ack to target 0x05.
    got_q.delete();
    run_packet(1'b0, 8'h05, 0, -1, '0, 0, 100, 64'd0, -1);
    check("wack_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check("wack_header", 64'(got_q[0]), 64'h1_0000_0005);
      check("wack_tail", 64'(got_q[1]), 64'h3_0000_0000);
    end
    check("wack_msrc", 64'(last_msrc), 64'h05);

    // Read burst A, B, C to target 0x12.
    got_q.delete();
    run_packet(1'b1, 8'h12, 3, 2, 32'hA, 0, 100, 64'd0, -1);
    check("read_count", 64'(got_q.size()), 64'(4));
    if (got_q.size() == 4) begin
      check("read_header", 64'(got_q[0]), 64'h1_8000_0012);
      check("read_body0", 64'(got_q[1]), 64'h2_0000_000A);
      check("read_body1", 64'(got_q[2]), 64'h2_0000_000B);
      check("read_tail", 64'(got_q[3]), 64'h3_0000_000C);
    end
    check("read_msrc", 64'(last_msrc), 64'h12);
    check("read_no_overrun", 64'(burst_overrun), 64'(0));

    // Stall 3 cycles on the header, then 2 cycles on the second beat.
    got_q.delete();
    run_packet(1'b1, 8'h33, 3, 2, 32'h100, 0, 100, 64'b110_0111, -1);
    check("stall_count", 64'(got_q.size()), 64'(4));
    if (got_q.size() == 4) begin
      check("stall_header", 64'(got_q[0]), 64'h1_8000_0033);
      check("stall_body0", 64'(got_q[1]), 64'h2_0000_0100);
      check("stall_body1", 64'(got_q[2]), 64'h2_0000_0101);
      check("stall_tail", 64'(got_q[3]), 64'h3_0000_0102);
    end

    // Ten beats, no resp_last: eighth beat becomes the tail.
    got_q.delete();
    run_packet(1'b1, 8'h44, 10, -1, 32'h200, 0, 100, 64'd0, -1);
    check("ovr_count", 64'(got_q.size()), 64'(9));
    if (got_q.size() == 9) begin
      check("ovr_body6", 64'(got_q[7]), 64'h2_0000_0206);
      check("ovr_tail", 64'(got_q[8]), 64'h3_0000_0207);
    end
    check("ovr_flag", 64'(burst_overrun), 64'(1));
    run_packet(1'b1, 8'h45, 2, 1, 32'h300, 20, 80, 64'd0, -1);

    // Reset after two beats, then a fresh packet.
    run_packet(1'b1, 8'h66, 5, 4, 32'h400, 0, 100, 64'd0, 2);
    check("post_reset_overrun", 64'(burst_overrun), 64'(0));
    got_q.delete();
    run_packet(1'b0, 8'h5A, 0, -1, '0, 0, 100, 64'd0, -1);
    check("post_reset_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() >= 1) check("post_reset_header", 64'(got_q[0]), 64'h1_0000_005A);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      logic rd;
      int   nb;
      int   li;
      rd = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 12);
      li = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, nb - 1);
      if ((li < 0 || li >= MB) && nb < MB) nb = MB;
      run_packet(rd, SW'($urandom), nb, li, '0, 30, 70, 64'd0, -1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    check("final_done_q_empty", 64'(done_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
